// File: rtl/adc_serial_ctrl.sv
// adc_serial_ctrl: LTC2308-style conversion controller for the DE0-Nano-SoC ADC.
// Each frame pulses CONVST and waits out the conversion. It then clocks the 6-bit
// config word out on adc_sdi and the 12-bit result in from adc_sdo, using a gated copy
// of the divided serial clock sck_in. The config word selects the channel for the
// following conversion, so each result is tagged with the channel sent one frame earlier.
// Build option: define ADC_SCAN_EN to make the block free-run, cycling channels 0..7.
`timescale 1ns/1ps
module adc_serial_ctrl #(
  parameter int CONV_HI_CYCLES   = 4,
  parameter int CONV_WAIT_CYCLES = 80,
  parameter int DATA_W           = 12,
  parameter bit CFG_UNI          = 1'b1
) (
  input  logic              clockin50mHz,
  input  logic              reset_n,
  input  logic              sck_in,
  input  logic              start,
  input  logic [2:0]        channel,
  output logic              adc_convst,
  output logic              adc_sck,
  output logic              adc_sdi,
  input  logic              adc_sdo,
  output logic              busy,
  output logic              data_valid,
  output logic [DATA_W-1:0] data,
  output logic [2:0]        data_ch
);

  localparam int CNT_MAX = (CONV_WAIT_CYCLES > CONV_HI_CYCLES) ? CONV_WAIT_CYCLES : CONV_HI_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_HI_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CONV_WAIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_WAIT, S_ALIGN, S_SHIFT, S_DONE
  } state_t;

  state_t            state;
  logic              sck_p1;
  logic              sck_rise;
  logic              sck_fall;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [5:0]        cfg_sh;
  logic [5:0]        cfg_cur;
  logic [DATA_W-1:0] data_sh;
  logic [2:0]        cur_ch;
  logic [2:0]        prev_ch;
  logic              go;
  logic [2:0]        next_ch;

  // Config word layout: S/D, O/S, S1, S0, UNI, SLP (single-ended, awake).
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], CFG_UNI, 1'b0};
  endfunction

  assign cfg_cur  = cfg_word(cur_ch);
  assign sck_rise = sck_in & ~sck_p1;
  assign sck_fall = ~sck_in & sck_p1;

`ifdef ADC_SCAN_EN
  logic [2:0] scan_ch;
  logic       unused_inputs;
  assign unused_inputs = ^{start, channel};
  assign go      = 1'b1;
  assign next_ch = scan_ch;
`else
  assign go      = start;
  assign next_ch = channel;
`endif

  // Delayed copy of the divided clock for edge detection.
  always_ff @(posedge clockin50mHz or negedge reset_n) begin
    if (!reset_n) sck_p1 <= 1'b0;
    else          sck_p1 <= sck_in;
  end

  // Frame sequencer: convst pulse, conversion wait, clock alignment, serial shift, result.
  always_ff @(posedge clockin50mHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      cfg_sh     <= '0;
      data_sh    <= '0;
      cur_ch     <= '0;
      prev_ch    <= '0;
      adc_convst <= 1'b0;
      adc_sck    <= 1'b0;
      adc_sdi    <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data       <= '0;
      data_ch    <= '0;
`ifdef ADC_SCAN_EN
      scan_ch    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            cur_ch     <= next_ch;
            busy       <= 1'b1;
            adc_convst <= 1'b1;
            cnt        <= '0;
            state      <= S_CONV;
`ifdef ADC_SCAN_EN
            scan_ch    <= scan_ch + 3'd1;
`endif
          end
        end
        S_CONV: begin
          if (cnt == CONV_LAST) begin
            adc_convst <= 1'b0;
            cnt        <= '0;
            state      <= S_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt     <= '0;
            cfg_sh  <= cfg_cur;
            adc_sdi <= cfg_cur[5];
            bit_cnt <= '0;
            data_sh <= '0;
            state   <= S_ALIGN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ALIGN: begin
          // Entering on a fall guarantees the first adc_sck high phase is full length.
          if (sck_fall) state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (sck_rise && (bit_cnt != BIT_LAST)) begin
            adc_sck <= 1'b1;
            data_sh <= {data_sh[DATA_W-2:0], adc_sdo};
            bit_cnt <= bit_cnt + BIT_W'(1);
          end else if (sck_fall) begin
            adc_sck <= 1'b0;
            cfg_sh  <= {cfg_sh[4:0], 1'b0};
            adc_sdi <= cfg_sh[4];
            if (bit_cnt == BIT_LAST) begin
              data       <= data_sh;
              data_ch    <= prev_ch;
              prev_ch    <= cur_ch;
              data_valid <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          data_valid <= 1'b0;
          busy       <= 1'b0;
          bit_cnt    <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Testbench for adc_serial_ctrl: directed frames with random channels and ADC
// results, checked against a channel-pipeline reference model and an ADC SDO model.
`timescale 1ns/1ps
module tb_adc_serial_ctrl;

  logic        clk;
  logic        reset_n;
  logic        sck_in;
  logic        start;
  logic [2:0]  channel;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;
  logic        busy;
  logic        data_valid;
  logic [11:0] data;
  logic [2:0]  data_ch;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor / ADC model state
  logic        mon_clr;
  logic [11:0] sdo_word;
  logic [11:0] sdo_sh = '0;
  int          n_sck = 0;
  int          n_valid = 0;
  int          conv_hi = 0;
  logic [5:0]  sdi_bits = '0;
  int          t_cv_fall = 0;
  int          t_first_sck = 0;
  int          t_busy_rise = 0;
  int          t_valid = 0;
  logic [11:0] cap_data = '0;
  logic [2:0]  cap_ch = '0;
  logic        cv_q = 1'b0;
  logic        sk_q = 1'b0;
  logic        bz_q = 1'b0;

  logic [2:0]  model_prev;
  logic [2:0]  ch;
  logic [11:0] w;
  logic [11:0] w2;
  bit          ok;

  adc_serial_ctrl dut (
    .clockin50mHz(clk),
    .reset_n     (reset_n),
    .sck_in      (sck_in),
    .start       (start),
    .channel     (channel),
    .adc_convst  (adc_convst),
    .adc_sck     (adc_sck),
    .adc_sdi     (adc_sdi),
    .adc_sdo     (adc_sdo),
    .busy        (busy),
    .data_valid  (data_valid),
    .data        (data),
    .data_ch     (data_ch)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Divided serial clock: period 8 system cycles, edges 1 ns after a rising clk edge
  initial begin
    sck_in = 1'b0;
    #11;
    forever begin
      sck_in = ~sck_in;
      #80;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ADC presents the MSB first and moves to the next bit after each adc_sck pulse
  assign adc_sdo = sdo_sh[11];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_sck       <= 0;
      n_valid     <= 0;
      conv_hi     <= 0;
      sdi_bits    <= '0;
      t_cv_fall   <= 0;
      t_first_sck <= 0;
      t_busy_rise <= 0;
      t_valid     <= 0;
      sdo_sh      <= sdo_word;
    end else begin
      if (adc_convst) conv_hi <= conv_hi + 1;
      if (!adc_convst && cv_q) t_cv_fall <= cyc;
      if (busy && !bz_q) t_busy_rise <= cyc;
      if (adc_sck && !sk_q) begin
        if (n_sck == 0) t_first_sck <= cyc;
        if (n_sck < 6) sdi_bits <= {sdi_bits[4:0], adc_sdi};
        n_sck  <= n_sck + 1;
        sdo_sh <= {sdo_sh[10:0], 1'b0};
      end
      if (data_valid) begin
        n_valid  <= n_valid + 1;
        t_valid  <= cyc;
        cap_data <= data;
        cap_ch   <= data_ch;
      end
    end
    cv_q <= adc_convst;
    sk_q <= adc_sck;
    bz_q <= busy;
  end

  function automatic logic [5:0] cfg_of(input logic [2:0] c);
    return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_frame(input logic [2:0] c, input logic [11:0] word);
    @(posedge clk); #2;
    sdo_word = word;
    mon_clr  = 1'b1;
    @(posedge clk); #2;
    mon_clr  = 1'b0;
    channel  = c;
    start    = 1'b1;
    @(posedge clk); #2;
    start    = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (n_valid != 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_sck(input int n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (n_sck >= n) begin
        got = 1'b1;
        break;
      end
    end
    check("sck_wait_timeout", 32'(got), 32'd1);
  endtask

  task automatic verify_frame(input logic [2:0] c, input logic [11:0] word, input logic [2:0] exp_ch);
    int lat;
    lat = t_valid - t_busy_rise;
    check("valid_count", 32'(n_valid), 32'd1);
    check("data", 32'(cap_data), 32'(word));
    check("data_ch", 32'(cap_ch), 32'(exp_ch));
    check("sck_pulses", 32'(n_sck), 32'd12);
    check("cfg_bits", 32'(sdi_bits), 32'(cfg_of(c)));
    check("convst_high", 32'(conv_hi), 32'd4);
    check("conv_gap_ge80", 32'((t_first_sck - t_cv_fall) >= 80), 32'd1);
    check("latency_window", 32'((lat >= 181) && (lat <= 188)), 32'd1);
  endtask

  task automatic post_idle();
    repeat (3) @(negedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("single_valid", 32'(n_valid), 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    channel    = 3'd0;
    mon_clr    = 1'b0;
    sdo_word   = '0;
    model_prev = 3'd0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs",
          32'({adc_convst, adc_sck, adc_sdi, busy, data_valid, data, data_ch}), 32'd0);
    reset_n = 1'b1;

`ifdef ADC_SCAN_EN
    for (int f = 0; f < 9; f++) begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (data_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("scan_timeout", 32'(seen), 32'd1);
      check("scan_data_ch", 32'(data_ch), (f == 0) ? 32'd0 : 32'((f - 1) % 8));
    end
`else
    // First frame after reset: channel 5, result A5C, reports channel 0
    begin_frame(3'd5, 12'hA5C);
    wait_valid("frame1_timeout");
    verify_frame(3'd5, 12'hA5C, model_prev);
    model_prev = 3'd5;
    post_idle();

    // Second frame: channel 2 reports the channel sent before (5)
    w = 12'($urandom);
    begin_frame(3'd2, w);
    wait_valid("frame2_timeout");
    verify_frame(3'd2, w, model_prev);
    model_prev = 3'd2;
    post_idle();

    // Random frames, including extreme result patterns
    for (int k = 0; k < 5; k++) begin
      ch = 3'($urandom_range(7, 0));
      w  = (k == 0) ? 12'hFFF : (k == 1) ? 12'h000 : 12'($urandom);
      begin_frame(ch, w);
      wait_valid("rand_timeout");
      verify_frame(ch, w, model_prev);
      model_prev = ch;
      post_idle();
    end

    // start held high: busy only drops for the IDLE cycle, then the next frame begins
    ch = 3'($urandom_range(7, 0));
    w  = 12'($urandom);
    @(posedge clk); #2;
    sdo_word = w;
    mon_clr  = 1'b1;
    @(posedge clk); #2;
    mon_clr  = 1'b0;
    channel  = ch;
    start    = 1'b1;
    wait_valid("hold_timeout");
    verify_frame(ch, w, model_prev);
    model_prev = ch;
    @(negedge clk); #1;
    check("hold_idle_gap", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("hold_reaccept", 32'(busy), 32'd1);
    w2 = 12'($urandom);
    @(posedge clk); #2;
    sdo_word = w2;
    mon_clr  = 1'b1;
    start    = 1'b0;
    @(posedge clk); #2;
    mon_clr  = 1'b0;
    wait_valid("hold2_timeout");
    check("hold2_data", 32'(cap_data), 32'(w2));
    check("hold2_data_ch", 32'(cap_ch), 32'(model_prev));
    check("hold2_cfg_bits", 32'(sdi_bits), 32'(cfg_of(ch)));
    check("hold2_sck_pulses", 32'(n_sck), 32'd12);
    model_prev = ch;
    post_idle();

    // start and a different channel during SHIFT must not disturb the frame
    ch = 3'($urandom_range(7, 0));
    w  = 12'($urandom);
    begin_frame(ch, w);
    wait_sck(3);
    @(posedge clk); #2;
    start   = 1'b1;
    channel = ~ch;
    repeat (2) @(posedge clk);
    #2;
    start   = 1'b0;
    wait_valid("midstart_timeout");
    verify_frame(ch, w, model_prev);
    model_prev = ch;
    post_idle();

    // Reset in the middle of SHIFT aborts at once and leaves the block idle
    ch = 3'($urandom_range(7, 0));
    w  = 12'($urandom);
    begin_frame(ch, w);
    wait_sck(5);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_shift",
          32'({adc_convst, adc_sck, adc_sdi, busy, data_valid, data, data_ch}), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_clr = 1'b1;
    @(posedge clk); #2;
    mon_clr = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    check("no_valid_after_reset", 32'(n_valid), 32'd0);
    check("idle_after_reset", 32'({busy, adc_convst, adc_sck}), 32'd0);
    model_prev = 3'd0;

    // First frame after the reset reports channel 0 again
    ch = 3'($urandom_range(7, 0));
    w  = 12'($urandom);
    begin_frame(ch, w);
    wait_valid("post_reset_timeout");
    verify_frame(ch, w, model_prev);
    model_prev = ch;
    post_idle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
